// File: rtl/muldiv_unit.sv
// muldiv_unit: RISC-V M-extension multiply/divide unit (radix-2 shift-add multiply, restoring divide).
// Define MULDIV_FAST_MUL_EN to complete all multiplies in one cycle with an array multiplier.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  flush,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] operand_A,
  input  logic [DATA_WIDTH-1:0] operand_B,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  busy,
  output logic                  done
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        r_state, w_nextState;
  logic [CW-1:0] r_count;
  logic [2:0]    r_op;
  logic          r_neg;
  logic [W-1:0]  r_hi, r_lo, r_b;

  logic          w_aSigned, w_bSigned, w_aNeg, w_bNeg;
  logic [W-1:0]  w_aMag, w_bMag;
  logic          w_divZero, w_overflow, w_special, w_fast, w_accept, w_lastStep;
  logic [W-1:0]  w_specialResult, w_fastResult;
  logic [W:0]    w_sum, w_diff;
  logic          w_fits;
  logic [W-1:0]  w_shiftLo, w_stepHi, w_stepLo, w_prodHi, w_quot, w_rem, w_finalResult;

  always_comb begin
    w_aSigned = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    w_bSigned = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
  end

  assign w_aNeg = w_aSigned & operand_A[W-1];
  assign w_bNeg = w_bSigned & operand_B[W-1];
  assign w_aMag = w_aNeg ? -operand_A : operand_A;
  assign w_bMag = w_bNeg ? -operand_B : operand_B;

  // Division corner cases resolve in a single edge without iterating
  assign w_divZero  = op[2] & (operand_B == '0);
  assign w_overflow = op[2] & ~op[0] & (operand_A == {1'b1, {(W-1){1'b0}}}) & (&operand_B);
  assign w_special  = w_divZero | w_overflow;
  assign w_specialResult = w_divZero ? (op[1] ? operand_A : '1) : (op[1] ? '0 : operand_A);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*W-1:0] w_extA, w_extB, w_fastProd;
  assign w_extA       = {{W{w_aNeg}}, operand_A};
  assign w_extB       = {{W{w_bNeg}}, operand_B};
  assign w_fastProd   = w_extA * w_extB;
  assign w_fast       = w_special | ~op[2];
  assign w_fastResult = w_special ? w_specialResult :
                        ((op[1:0] == 2'b00) ? w_fastProd[W-1:0] : w_fastProd[2*W-1:W]);
`else
  assign w_fast       = w_special;
  assign w_fastResult = w_specialResult;
`endif

  assign w_accept   = start & ~flush & (r_state != CALC);
  assign w_lastStep = (r_count == CW'(W-1));

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = w_fast ? DONE : CALC;
      CALC:    if (flush) w_nextState = IDLE;
               else if (w_lastStep) w_nextState = DONE;
      DONE:    if (w_accept) w_nextState = w_fast ? DONE : CALC;
               else w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == CALC);
    done = (r_state == DONE);
  end

  // One iteration step; r_hi/r_lo hold product halves or remainder/quotient
  always_comb begin
    w_sum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_diff    = {r_hi, r_lo[W-1]} - {1'b0, r_b};
    w_shiftLo = {r_hi[W-2:0], r_lo[W-1]};
    w_fits    = ~w_diff[W];
    if (r_op[2]) begin
      w_stepHi = w_fits ? w_diff[W-1:0] : w_shiftLo;
      w_stepLo = {r_lo[W-2:0], w_fits};
    end else begin
      w_stepHi = w_sum[W:1];
      w_stepLo = {w_sum[0], r_lo[W-1:1]};
    end
    w_prodHi = r_neg ? (~w_stepHi + {{(W-1){1'b0}}, (w_stepLo == '0)}) : w_stepHi;
    w_quot   = r_neg ? -w_stepLo : w_stepLo;
    w_rem    = r_neg ? -w_stepHi : w_stepHi;
    if (r_op[2]) w_finalResult = r_op[1] ? w_rem : w_quot;
    else         w_finalResult = (r_op[1:0] == 2'b00) ? w_stepLo : w_prodHi;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      result  <= '0;
      r_count <= '0;
      r_op    <= '0;
      r_neg   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_b     <= '0;
    end else if (w_accept) begin
      r_op    <= op;
      r_neg   <= (op[2] & op[1]) ? w_aNeg : (w_aNeg ^ w_bNeg);
      r_count <= '0;
      r_hi    <= '0;
      r_lo    <= op[2] ? w_aMag : w_bMag;
      r_b     <= op[2] ? w_bMag : w_aMag;
      if (w_fast) result <= w_fastResult;
    end else if ((r_state == CALC) && !flush) begin
      r_hi    <= w_stepHi;
      r_lo    <= w_stepLo;
      r_count <= r_count + 1'b1;
      if (w_lastStep) result <= w_finalResult;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit, comparing against a 64-bit arithmetic model.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset, start, flush;
  logic [2:0]   op;
  logic [W-1:0] operand_A, operand_B, result;
  logic         busy, done;

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  muldiv_unit #(.DATA_WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .flush(flush), .op(op),
    .operand_A(operand_A), .operand_B(operand_B),
    .result(result), .busy(busy), .done(done)
  );

  // Reference result computed from the M-extension rules using 64-bit arithmetic
  function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = longint'(sa * sb); return p[63:32]; end
      3'd2: begin p = longint'(sa * longint'(ub)); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        return 32'(sa / sb);
      end
      3'd5: begin
        if (b == 0) return 32'hFFFFFFFF;
        return 32'(ua / ub);
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: begin
        if (b == 0) return a;
        return 32'(ua % ub);
      end
    endcase
  endfunction

  // Edges after the start edge until done is visible
  function automatic int expLatency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 0;
`ifdef MULDIV_FAST_MUL_EN
    if (!f[2]) return 0;
`endif
    return W;
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Launches one op from a negedge and returns at the negedge where done is seen
  task automatic runOp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output int busyCnt);
    op = f; operand_A = a; operand_B = b; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0; op = 3'($urandom); operand_A = $urandom; operand_B = $urandom;
    lat = 0; busyCnt = 0;
    while (!done && lat < 200) begin
      if (busy) busyCnt++;
      @(negedge clock);
      lat++;
    end
    if (!done) begin
      mismatched++;
      $display("[TB] FAIL timeout: done=%b required 1 within 200 edges", done);
    end
    compared++;
    res = result;
  endtask

  task automatic test_reset();
    if ({result, busy, done} !== {32'h0, 1'b0, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL reset_state: result=%h busy=%b done=%b required 0/0/0", result, busy, done);
    end
    compared++;
  endtask

  task automatic test_mul_directed();
    logic [31:0] res;
    int lat, bc, expBusy;
    logic [2:0] ops[4] = '{3'd3, 3'd1, 3'd2, 3'd0};
    logic [31:0] exps[4] = '{32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF, 32'h00000001};
    expBusy = (expLatency(3'd0, 7, 32'hFFFFFFFD) == 0) ? 0 : W;
    runOp(3'd0, 32'd7, 32'hFFFFFFFD, res, lat, bc);
    if (res !== 32'hFFFFFFEB) begin mismatched++; $display("[TB] FAIL mul_7x-3: got %h required FFFFFFEB", res); end
    compared++;
    if (lat !== expLatency(3'd0, 7, 32'hFFFFFFFD)) begin mismatched++; $display("[TB] FAIL mul_latency: got %0d required %0d", lat, expLatency(3'd0, 7, 32'hFFFFFFFD)); end
    compared++;
    if (bc !== expBusy) begin mismatched++; $display("[TB] FAIL mul_busy_cycles: got %0d required %0d", bc, expBusy); end
    compared++;
    @(negedge clock);
    if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL done_one_cycle: done=%b required 0", done); end
    compared++;
    for (int i = 0; i < 4; i++) begin
      runOp(ops[i], 32'hFFFFFFFF, 32'hFFFFFFFF, res, lat, bc);
      if (res !== exps[i]) begin mismatched++; $display("[TB] FAIL mul_ones op=%0d: got %h required %h", ops[i], res, exps[i]); end
      compared++;
    end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    int lat, bc;
    logic [2:0] ops[4] = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] as[4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
    logic [31:0] bs[4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] exps[4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
    for (int i = 0; i < 4; i++) begin
      runOp(ops[i], as[i], bs[i], res, lat, bc);
      if (res !== exps[i] || lat !== W) begin
        mismatched++;
        $display("[TB] FAIL div_b2b op=%0d: got %h lat %0d required %h lat %0d", ops[i], res, lat, exps[i], W);
      end
      compared++;
    end
    @(negedge clock);
  endtask

  task automatic test_special();
    logic [31:0] res;
    int lat, bc;
    logic [2:0] ops[6] = '{3'd4, 3'd7, 3'd4, 3'd6, 3'd5, 3'd6};
    logic [31:0] as[6] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'd9, 32'hFFFFFFF0};
    logic [31:0] bs[6] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
    logic [31:0] exps[6] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF0};
    for (int i = 0; i < 6; i++) begin
      runOp(ops[i], as[i], bs[i], res, lat, bc);
      if (res !== exps[i] || lat !== 0 || bc !== 0) begin
        mismatched++;
        $display("[TB] FAIL special op=%0d: got %h lat %0d busy %0d required %h lat 0 busy 0", ops[i], res, lat, bc, exps[i]);
      end
      compared++;
    end
    @(negedge clock);
  endtask

  task automatic test_flush();
    logic [31:0] prev;
    bit sawDone;
    prev = result;
    op = 3'd5; operand_A = 32'd100; operand_B = 32'd7; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    flush = 1'b1;
    @(posedge clock);
    @(negedge clock);
    flush = 1'b0;
    if (busy !== 1'b0 || done !== 1'b0 || result !== prev) begin
      mismatched++;
      $display("[TB] FAIL flush_abort: busy=%b done=%b result=%h required 0/0/%h", busy, done, result, prev);
    end
    compared++;
    sawDone = 0;
    repeat (40) begin @(negedge clock); if (done) sawDone = 1; end
    if (sawDone !== 1'b0 || result !== prev) begin
      mismatched++;
      $display("[TB] FAIL flush_no_done: sawDone=%b result=%h required 0/%h", sawDone, result, prev);
    end
    compared++;
    op = 3'd4; operand_A = 32'd5; operand_B = 32'd0; start = 1'b1; flush = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0; flush = 1'b0;
    if (busy !== 1'b0 || done !== 1'b0 || result !== prev) begin
      mismatched++;
      $display("[TB] FAIL flush_beats_start: busy=%b done=%b result=%h required 0/0/%h", busy, done, result, prev);
    end
    compared++;
  endtask

  task automatic test_busy_start();
    int lat;
    op = 3'd5; operand_A = 32'd100; operand_B = 32'd7; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    lat = 0;
    while (!done && lat < 200) begin
      start = (lat % 4 == 1); op = 3'd4; operand_A = 32'd5; operand_B = 32'd0;
      @(negedge clock);
      lat++;
    end
    start = 1'b0;
    if (result !== 32'd14 || lat !== W) begin
      mismatched++;
      $display("[TB] FAIL start_while_busy: got %h lat %0d required 0000000e lat %0d", result, lat, W);
    end
    compared++;
    @(negedge clock);
  endtask

  task automatic test_reset_midcalc();
    logic [31:0] res;
    int lat, bc;
    op = 3'd5; operand_A = 32'd1000; operand_B = 32'd3; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    if ({result, busy, done} !== {32'h0, 1'b0, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL reset_midcalc: result=%h busy=%b done=%b required 0/0/0", result, busy, done);
    end
    compared++;
    reset = 1'b0;
    runOp(3'd5, 32'd100, 32'd7, res, lat, bc);
    if (res !== 32'd14 || lat !== W) begin
      mismatched++;
      $display("[TB] FAIL after_reset: got %h lat %0d required 0000000e lat %0d", res, lat, W);
    end
    compared++;
    @(negedge clock);
  endtask

  task automatic test_random();
    logic [31:0] res, a, b, expRes;
    logic [2:0] f;
    int lat, bc, expLat;
    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pickOperand();
      b = pickOperand();
      expRes = refModel(f, a, b);
      expLat = expLatency(f, a, b);
      runOp(f, a, b, res, lat, bc);
      if (res !== expRes || lat !== expLat) begin
        mismatched++;
        $display("[TB] FAIL random op=%0d a=%h b=%h: got %h lat %0d required %h lat %0d", f, a, b, res, lat, expRes, expLat);
      end
      compared++;
      if ($urandom_range(0, 1) == 1) @(negedge clock);
    end
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; operand_A = '0; operand_B = '0;
    repeat (3) @(negedge clock);
    test_reset();
    reset = 1'b0;
    @(negedge clock);
    test_mul_directed();
    test_back_to_back();
    test_special();
    test_flush();
    test_busy_start();
    test_reset_midcalc();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
